userio_spi_master: RTL and testbench
====================================

# userio_spi_master

SPI master that initiates single-byte full-duplex transfers toward the userio SPI slaves (OSD, config), generating `_scs` and `sck` from the system clock. It speaks the same wire protocol the slaves expect: sck idle high, data sampled on the rising edge, data changed on the falling edge, MSB first. A byte-level start/done handshake on the `clk` side lets a controller issue commands and data bytes without managing the wire protocol itself.

## Interface
- `DIV`, 2: number of `clk7_en` ticks per sck half-period; legal range 1..16.
- `clk`  in  1  system clock.
- `_rst`  in  1  asynchronous, active-low reset.
- `clk7_en`  in  1  tick enable; all wire-level timing advances only on ticks.
- `start`  in  1  request a byte transfer; accepted on any `clk` cycle with `busy`=0.
- `last`  in  1  sampled with `start`; 1 = deassert `_scs` after this byte.
- `deselect`  in  1  while holding CS between bytes, end the transaction.
- `din`  in  8  byte to send; sampled at accept.
- `dout`  out  8  byte received in the last transfer.
- `busy`  out  1  transfer or CS gap in progress; `start` ignored.
- `done`  out  1  one-`clk` pulse when `dout` is updated.
- `_scs`  out  1  SPI chip select, active low.
- `sck`  out  1  SPI clock.
- `sdo`  out  1  serial data to slave `sdi`.
- `sdi`  in  1  serial data from slave `sdo`.

## Operation
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP. A half-period counter `hcnt` runs 0..DIV-1 on ticks; a phase ends on the tick where `hcnt`=DIV-1.
- IDLE: `_scs`=1, `sck`=1, `busy`=0. On `start`, latch `din` and `last`, set `_scs`=0, set `sdo`=din[7], set `busy`=1, then go to SETUP.
- SETUP: at phase end, set `sck`=0 and go to LOW.
- LOW: at phase end, set `sck`=1, shift `sdi` into the rx register, then go to HIGH.
- HIGH, bits remaining: at phase end, set `sck`=0, put the next bit on `sdo`, increment the bit count, then go to LOW.
- HIGH, 8th bit: at phase end, set `dout`=rx and pulse `done`.
  - If `last`=1, set `_scs`=1 and go to GAP.
  - Otherwise go to HOLD.
- HOLD: `_scs`=0, `sck`=1, `busy`=0.
  - On `start`: latch `din`/`last`, set `sck`=0 and `sdo`=din[7] in the same cycle, then go to LOW.
  - On `deselect` without `start`: set `_scs`=1 and go to GAP.
  - If `start` and `deselect` arrive together, `start` wins and `deselect` is ignored.
- GAP: `_scs`=1, `busy`=1 for DIV ticks, then go to IDLE.
- `sdi` is sampled without a synchronizer; the slave keeps it stable for at least DIV ticks before each rising edge.
- `start` while `busy`=1 is ignored, not queued.
- `deselect` outside HOLD is ignored.

## Timing
- Reset values: `_scs`=1, `sck`=1, `sdo`=0, `busy`=0, `done`=0, `dout`=8'h00, state IDLE, counters 0. Reset mid-transfer returns all outputs to these values immediately, with no partial `done`.
- Accept-to-`done`, from IDLE: 17·DIV ticks (SETUP + 8 LOW + 8 HIGH).
- Accept-to-`done`, from HOLD: 16·DIV ticks.
- `done` is asserted for exactly one `clk` cycle, coincident with the final sck-high phase end.
- `dout` is stable from `done` until the next `done`.
- `busy` rises the cycle after accept. It falls with `done` when entering HOLD, or at the end of GAP.
- Minimum `_scs` high time between transactions: DIV ticks.
- `_scs` falls at least DIV ticks before the first sck falling edge.

## Structure
- Shared package/include `userio_spi_defs`: SPI mode constants (CPOL=1, sample-on-rise, MSB first) and the byte width 8, common to slave and master.
- State encoding stays local to this module.
- Single module; no sub-module is needed (the tick/half-period counter is a few lines inline).

## Test plan
- Single byte:
  - Stimulus: DIV=1, `clk7_en` always 1, OSD slave model with `in`=8'h3C, send `din`=8'hA5 with `last`=1.
  - Required: `done` exactly 17 cycles after accept; `dout`=8'h3C; slave `out`=8'hA5 with `cmd`=1; `_scs` high 1 cycle later.
- Held chip select:
  - Stimulus: DIV=2, send 8'h12 with `last`=0, then 8'h34 with `last`=1 while in HOLD.
  - Required: `_scs` stays low throughout; second `done` 32 ticks after second accept; slave sees `cmd` 1 then 0.
- Deselect in HOLD:
  - Stimulus: `deselect` in HOLD; next, `start` and `deselect` asserted together in HOLD.
  - Required: `_scs`=1 and GAP for DIV ticks; in the simultaneous case the transfer starts and `_scs` stays low.
- Start while busy:
  - Stimulus: `start` pulses during a transfer.
  - Required: ignored; exactly one `done`; `dout` unchanged by the ignored request.
- Reset mid-transfer:
  - Stimulus: `_rst` low after the 4th rising sck edge.
  - Required: `_scs`=1, `sck`=1, `busy`=0, `dout`=8'h00 in the same cycle; next transfer completes normally.
- Tick gating:
  - Stimulus: `clk7_en` 1 cycle in 4, DIV=3.
  - Required: each sck half-period is 12 clk cycles; sck edges occur only on tick cycles.

Source files
------------

// File: rtl/userio_spi_defs.sv
// Wire-protocol constants shared by the userio SPI master and slaves:
// sck idles high, data is sampled on the rising edge and shifted MSB first.
package userio_spi_defs;

    localparam int   SPI_BYTE_W      = 8;
    localparam logic SPI_CPOL        = 1'b1;
    localparam logic SPI_SAMPLE_RISE = 1'b1;
    localparam logic SPI_MSB_FIRST   = 1'b1;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

    // Bit that goes on the wire first from a shift register.
    function automatic logic spi_tx_bit(input spi_byte_t cur);
        return SPI_MSB_FIRST ? cur[SPI_BYTE_W-1] : cur[0];
    endfunction

    function automatic spi_byte_t spi_shift_out(input spi_byte_t cur);
        return SPI_MSB_FIRST ? {cur[SPI_BYTE_W-2:0], 1'b0} : {1'b0, cur[SPI_BYTE_W-1:1]};
    endfunction

    function automatic spi_byte_t spi_shift_in(input spi_byte_t cur, input logic b);
        return SPI_MSB_FIRST ? {cur[SPI_BYTE_W-2:0], b} : {b, cur[SPI_BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/userio_spi_master.sv
// Single-byte full-duplex SPI master for the userio slaves, with a byte-level
// start/done handshake and optional chip-select hold between bytes.
module userio_spi_master
    import userio_spi_defs::*;
#(
    parameter int DIV = 2
)
(
    input  logic                  clk,
    input  logic                  _rst,
    input  logic                  clk7_en,
    input  logic                  start,
    input  logic                  last,
    input  logic                  deselect,
    input  logic [SPI_BYTE_W-1:0] din,
    output logic [SPI_BYTE_W-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  _scs,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HW-1:0] HLAST = HW'(DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic [HW-1:0] hcnt_reg,  hcnt_next;
    logic [2:0]    bit_reg,   bit_next;
    spi_byte_t     tx_reg,    tx_next;
    spi_byte_t     rx_reg,    rx_next;
    spi_byte_t     dout_reg,  dout_next;
    logic          last_reg,  last_next;
    logic          done_reg,  done_next;
    logic          busy_reg,  busy_next;
    logic          scs_reg,   scs_next;
    logic          sck_reg,   sck_next;
    logic          sdo_reg,   sdo_next;

    logic counting;
    logic phase_end;

    // The half-period counter only runs in the timed states; IDLE and HOLD park it at 0.
    assign counting  = (state_reg == ST_SETUP) || (state_reg == ST_LOW) ||
                       (state_reg == ST_HIGH)  || (state_reg == ST_GAP);
    assign phase_end = counting && clk7_en && (hcnt_reg == HLAST);

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        dout_next  = dout_reg;
        last_next  = last_reg;
        done_next  = 1'b0;
        busy_next  = busy_reg;
        scs_next   = scs_reg;
        sck_next   = sck_reg;
        sdo_next   = sdo_reg;

        if (counting && clk7_en) begin
            hcnt_next = phase_end ? '0 : hcnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    tx_next    = din;
                    last_next  = last;
                    scs_next   = 1'b0;
                    sdo_next   = spi_tx_bit(din);
                    busy_next  = 1'b1;
                    bit_next   = 3'd0;
                    hcnt_next  = '0;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    sck_next   = ~SPI_CPOL;
                    state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    sck_next   = SPI_CPOL;
                    rx_next    = spi_shift_in(rx_reg, sdi);
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    if (bit_reg == 3'd7) begin
                        dout_next = rx_reg;
                        done_next = 1'b1;
                        if (last_reg) begin
                            scs_next   = 1'b1;
                            state_next = ST_GAP;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = ST_HOLD;
                        end
                    end else begin
                        sck_next   = ~SPI_CPOL;
                        tx_next    = spi_shift_out(tx_reg);
                        sdo_next   = spi_tx_bit(spi_shift_out(tx_reg));
                        bit_next   = bit_reg + 3'd1;
                        state_next = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                // A new byte skips SETUP: chip select is already low, so sck falls at once.
                if (start) begin
                    tx_next    = din;
                    last_next  = last;
                    sck_next   = ~SPI_CPOL;
                    sdo_next   = spi_tx_bit(din);
                    busy_next  = 1'b1;
                    bit_next   = 3'd0;
                    hcnt_next  = '0;
                    state_next = ST_LOW;
                end else if (deselect) begin
                    scs_next   = 1'b1;
                    busy_next  = 1'b1;
                    hcnt_next  = '0;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                scs_next   = 1'b1;
                sck_next   = SPI_CPOL;
                hcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_reg <= ST_IDLE;
            hcnt_reg  <= '0;
            bit_reg   <= 3'd0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            dout_reg  <= '0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            scs_reg   <= 1'b1;
            sck_reg   <= SPI_CPOL;
            sdo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            dout_reg  <= dout_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            scs_reg   <= scs_next;
            sck_reg   <= sck_next;
            sdo_reg   <= sdo_next;
        end
    end

    assign dout = dout_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign _scs = scs_reg;
    assign sck  = sck_reg;
    assign sdo  = sdo_reg;

endmodule

// File: tb/tb_userio_spi_master.sv
// Bench for userio_spi_master: three instances (DIV=1,2,3) each talking to a
// behavioural SPI slave; instance 2 runs with a 1-in-4 tick enable.
module tb_userio_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en_s;
    logic [2:0] start_s, last_s, deselect_s;
    logic [7:0] din_s [3];
    logic [2:0] sdi_s;
    wire  [7:0] dout_w [3];
    wire  [2:0] busy_w, done_w, scs_w, sck_w, sdo_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        userio_spi_master #(.DIV(gi + 1)) u_dut (
            .clk(clk), ._rst(rst_n), .clk7_en(en_s[gi]),
            .start(start_s[gi]), .last(last_s[gi]), .deselect(deselect_s[gi]),
            .din(din_s[gi]), .dout(dout_w[gi]), .busy(busy_w[gi]), .done(done_w[gi]),
            ._scs(scs_w[gi]), .sck(sck_w[gi]), .sdo(sdo_w[gi]), .sdi(sdi_s[gi])
        );
    end

    // Tick enables: instances 0 and 1 tick every cycle, instance 2 one cycle in four.
    initial begin
        int gate_cnt;
        gate_cnt = 0;
        en_s = 3'b011;
        forever begin
            @(posedge clk);
            #2;
            gate_cnt++;
            en_s = {((gate_cnt % 4) == 0), 2'b11};
        end
    end

    // Behavioural slave: shifts sdo in on sck rise, drives sdi MSB first on sck fall,
    // flags the first byte after chip select falls as a command byte.
    logic [7:0] slave_tx [3];
    logic [7:0] rec_byte [3][64];
    bit         rec_cmd  [3][64];
    int         rec_cnt  [3];
    int         s_idx    [3];
    bit         s_first  [3];
    logic [7:0] s_sh     [3];
    logic [2:0] scs_prev, sck_prev;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (scs_w[k] !== 1'b0) begin
                s_idx[k] = 0;
            end else if (scs_prev[k] === 1'b1) begin
                s_idx[k]   = 0;
                s_first[k] = 1'b1;
                sdi_s[k]   = slave_tx[k][7];
            end else begin
                if (sck_w[k] === 1'b1 && sck_prev[k] === 1'b0) begin
                    s_sh[k] = {s_sh[k][6:0], sdo_w[k]};
                    s_idx[k]++;
                    if (s_idx[k] == 8) begin
                        rec_byte[k][rec_cnt[k] % 64] = s_sh[k];
                        rec_cmd[k][rec_cnt[k] % 64]  = s_first[k];
                        rec_cnt[k]++;
                        s_idx[k]   = 0;
                        s_first[k] = 1'b0;
                    end
                end
                if (sck_w[k] === 1'b0 && sck_prev[k] === 1'b1) begin
                    sdi_s[k] = slave_tx[k][7 - s_idx[k]];
                end
            end
            scs_prev[k] = scs_w[k];
            sck_prev[k] = sck_w[k];
        end
    end

    task automatic accept(input int k, input logic [7:0] d, input logic l);
        din_s[k] = d; last_s[k] = l; start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
    endtask

    // Cycles from now until done is seen (-1 on timeout); scs_hi flags a chip-select release before done.
    task automatic wait_done(input int k, input int budget, output int cyc, output bit scs_hi);
        cyc = 0; scs_hi = 1'b0;
        while (done_w[k] !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (scs_w[k] !== 1'b0 && done_w[k] !== 1'b1) scs_hi = 1'b1;
        end
        if (done_w[k] !== 1'b1) cyc = -1;
    endtask

    task automatic wait_idle(input int k, input int budget, output int cyc);
        cyc = 0;
        while (busy_w[k] !== 1'b0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy_w[k] !== 1'b0) cyc = -1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++; if (scs_w[k] !== 1'b1) begin errors++; $display("FAIL reset_scs inst=%0d got %b exp 1", k, scs_w[k]); end
            checks++; if (sck_w[k] !== 1'b1) begin errors++; $display("FAIL reset_sck inst=%0d got %b exp 1", k, sck_w[k]); end
            checks++; if (sdo_w[k] !== 1'b0) begin errors++; $display("FAIL reset_sdo inst=%0d got %b exp 0", k, sdo_w[k]); end
            checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst=%0d got %b exp 0", k, busy_w[k]); end
            checks++; if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done inst=%0d got %b exp 0", k, done_w[k]); end
            checks++; if (dout_w[k] !== 8'h00) begin errors++; $display("FAIL reset_dout inst=%0d got %h exp 00", k, dout_w[k]); end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy_w[k] !== 1'b0 || scs_w[k] !== 1'b1) begin errors++; $display("FAIL post_reset_idle inst=%0d busy=%b scs=%b exp 0/1", k, busy_w[k], scs_w[k]); end
        end
        $display("reset released");
    endtask

    task automatic test_single_byte();
        logic [7:0] d, s;
        int cyc, base;
        bit hi;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom);
            s = (i == 0) ? 8'h3C : 8'($urandom);
            slave_tx[0] = s;
            base = rec_cnt[0];
            accept(0, d, 1'b1);
            checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b exp 1", busy_w[0]); end
            wait_done(0, 100, cyc, hi);
            checks++; if (cyc !== 17) begin errors++; $display("FAIL single_latency got %0d exp 17", cyc); end
            checks++; if (dout_w[0] !== s) begin errors++; $display("FAIL single_dout got %h exp %h", dout_w[0], s); end
            checks++; if (hi !== 1'b0) begin errors++; $display("FAIL single_scs_early got %b exp 0", hi); end
            @(posedge clk); #1;
            checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", done_w[0]); end
            checks++; if (scs_w[0] !== 1'b1) begin errors++; $display("FAIL single_scs_after got %b exp 1", scs_w[0]); end
            checks++; if (rec_cnt[0] !== base + 1) begin errors++; $display("FAIL single_slave_count got %0d exp %0d", rec_cnt[0], base + 1); end
            checks++; if (rec_byte[0][base % 64] !== d || rec_cmd[0][base % 64] !== 1'b1) begin errors++; $display("FAIL single_slave_rx got %h cmd=%b exp %h cmd=1", rec_byte[0][base % 64], rec_cmd[0][base % 64], d); end
            wait_idle(0, 20, cyc);
            checks++; if (cyc < 0) begin errors++; $display("FAIL single_idle got timeout exp idle"); end
            $display("single inst=0 din=%h slave=%h dout=%h", d, s, dout_w[0]);
        end
    endtask

    task automatic test_held_cs();
        logic [7:0] d1, d2, s1, s2;
        int cyc, base, gap;
        bit hi;
        for (int i = 0; i < 3; i++) begin
            d1 = 8'($urandom); d2 = 8'($urandom); s1 = 8'($urandom); s2 = 8'($urandom);
            slave_tx[1] = s1;
            base = rec_cnt[1];
            accept(1, (i == 0) ? 8'h12 : d1, 1'b0);
            if (i == 0) d1 = 8'h12;
            wait_done(1, 200, cyc, hi);
            checks++; if (cyc !== 34) begin errors++; $display("FAIL held_latency1 got %0d exp 34", cyc); end
            checks++; if (dout_w[1] !== s1) begin errors++; $display("FAIL held_dout1 got %h exp %h", dout_w[1], s1); end
            checks++; if (busy_w[1] !== 1'b0 || scs_w[1] !== 1'b0) begin errors++; $display("FAIL held_hold_state busy=%b scs=%b exp 0/0", busy_w[1], scs_w[1]); end
            slave_tx[1] = s2;
            hi = 1'b0;
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                @(posedge clk); #1;
                if (scs_w[1] !== 1'b0) hi = 1'b1;
            end
            checks++; if (hi !== 1'b0) begin errors++; $display("FAIL held_scs_in_hold got high exp low"); end
            if (i == 0) d2 = 8'h34;
            accept(1, d2, 1'b1);
            wait_done(1, 200, cyc, hi);
            checks++; if (cyc !== 32) begin errors++; $display("FAIL held_latency2 got %0d exp 32", cyc); end
            checks++; if (hi !== 1'b0) begin errors++; $display("FAIL held_scs_low got high exp low"); end
            checks++; if (dout_w[1] !== s2) begin errors++; $display("FAIL held_dout2 got %h exp %h", dout_w[1], s2); end
            checks++; if (rec_cnt[1] !== base + 2) begin errors++; $display("FAIL held_slave_count got %0d exp %0d", rec_cnt[1], base + 2); end
            checks++; if (rec_byte[1][base % 64] !== d1 || rec_cmd[1][base % 64] !== 1'b1) begin errors++; $display("FAIL held_slave_b1 got %h cmd=%b exp %h cmd=1", rec_byte[1][base % 64], rec_cmd[1][base % 64], d1); end
            checks++; if (rec_byte[1][(base + 1) % 64] !== d2 || rec_cmd[1][(base + 1) % 64] !== 1'b0) begin errors++; $display("FAIL held_slave_b2 got %h cmd=%b exp %h cmd=0", rec_byte[1][(base + 1) % 64], rec_cmd[1][(base + 1) % 64], d2); end
            @(posedge clk); #1;
            wait_idle(1, 20, cyc);
            checks++; if (cyc !== 1) begin errors++; $display("FAIL held_gap_len got %0d exp 1 more cycle", cyc); end
            $display("held inst=1 din=%h,%h slave=%h,%h dout=%h", d1, d2, s1, s2, dout_w[1]);
        end
    endtask

    task automatic test_deselect();
        logic [7:0] d, d2, s2;
        int cyc, base;
        bit hi;
        d = 8'($urandom); d2 = 8'($urandom); s2 = 8'($urandom);
        slave_tx[1] = 8'($urandom);
        accept(1, d, 1'b0);
        wait_done(1, 200, cyc, hi);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        deselect_s[1] = 1'b1;
        @(posedge clk); #1;
        deselect_s[1] = 1'b0;
        checks++; if (scs_w[1] !== 1'b1 || busy_w[1] !== 1'b1) begin errors++; $display("FAIL desel_gap_entry scs=%b busy=%b exp 1/1", scs_w[1], busy_w[1]); end
        wait_idle(1, 20, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL desel_gap_len got %0d exp 2", cyc); end
        $display("deselect inst=1 din=%h gap=%0d", d, cyc);

        accept(1, d, 1'b0);
        wait_done(1, 200, cyc, hi);
        @(posedge clk); #1;
        slave_tx[1] = s2;
        base = rec_cnt[1];
        din_s[1] = d2; last_s[1] = 1'b1; start_s[1] = 1'b1; deselect_s[1] = 1'b1;
        @(posedge clk); #1;
        start_s[1] = 1'b0; deselect_s[1] = 1'b0;
        checks++; if (scs_w[1] !== 1'b0 || busy_w[1] !== 1'b1) begin errors++; $display("FAIL desel_both_start scs=%b busy=%b exp 0/1", scs_w[1], busy_w[1]); end
        wait_done(1, 200, cyc, hi);
        checks++; if (cyc !== 32 || hi !== 1'b0) begin errors++; $display("FAIL desel_both_xfer cyc=%0d scs_hi=%b exp 32/0", cyc, hi); end
        checks++; if (dout_w[1] !== s2) begin errors++; $display("FAIL desel_both_dout got %h exp %h", dout_w[1], s2); end
        checks++; if (rec_byte[1][base % 64] !== d2 || rec_cmd[1][base % 64] !== 1'b0) begin errors++; $display("FAIL desel_both_slave got %h cmd=%b exp %h cmd=0", rec_byte[1][base % 64], rec_cmd[1][base % 64], d2); end
        wait_idle(1, 20, cyc);
        $display("deselect+start inst=1 din=%h slave=%h dout=%h", d2, s2, dout_w[1]);
    endtask

    task automatic test_start_while_busy();
        logic [7:0] d, s;
        int cyc, base, ndone;
        bit hi;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom); s = 8'($urandom);
            slave_tx[1] = s;
            base = rec_cnt[1];
            accept(1, d, 1'b1);
            ndone = 0; hi = 1'b0; cyc = 0;
            while (busy_w[1] === 1'b1 && cyc < 200) begin
                start_s[1]    = 1'($urandom_range(0, 1));
                deselect_s[1] = 1'($urandom_range(0, 1));
                din_s[1]      = 8'($urandom);
                last_s[1]     = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                cyc++;
                if (done_w[1] === 1'b1) ndone++;
                if (scs_w[1] !== 1'b0 && ndone == 0) hi = 1'b1;
            end
            start_s[1] = 1'b0; deselect_s[1] = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                if (done_w[1] === 1'b1) ndone++;
            end
            checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
            checks++; if (hi !== 1'b0) begin errors++; $display("FAIL busy_scs_early got high exp low"); end
            checks++; if (dout_w[1] !== s) begin errors++; $display("FAIL busy_dout got %h exp %h", dout_w[1], s); end
            checks++; if (rec_cnt[1] !== base + 1 || rec_byte[1][base % 64] !== d) begin errors++; $display("FAIL busy_slave cnt=%0d byte=%h exp %0d/%h", rec_cnt[1], rec_byte[1][base % 64], base + 1, d); end
            checks++; if (busy_w[1] !== 1'b0 || scs_w[1] !== 1'b1) begin errors++; $display("FAIL busy_end_idle busy=%b scs=%b exp 0/1", busy_w[1], scs_w[1]); end
            $display("start_while_busy inst=1 din=%h slave=%h dout=%h", d, s, dout_w[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, s;
        int cyc, rises, base;
        bit hi;
        logic prev;
        d = 8'($urandom); s = 8'($urandom) | 8'h01;
        slave_tx[1] = s;
        accept(1, d, 1'b1);
        rises = 0; cyc = 0; prev = sck_w[1];
        while (rises < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (sck_w[1] === 1'b1 && prev === 1'b0) rises++;
            prev = sck_w[1];
        end
        checks++; if (rises !== 4) begin errors++; $display("FAIL rmid_rises got %0d exp 4", rises); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (scs_w[1] !== 1'b1 || sck_w[1] !== 1'b1) begin errors++; $display("FAIL rmid_wire scs=%b sck=%b exp 1/1", scs_w[1], sck_w[1]); end
        checks++; if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0) begin errors++; $display("FAIL rmid_flags busy=%b done=%b exp 0/0", busy_w[1], done_w[1]); end
        checks++; if (dout_w[1] !== 8'h00 || sdo_w[1] !== 1'b0) begin errors++; $display("FAIL rmid_data dout=%h sdo=%b exp 00/0", dout_w[1], sdo_w[1]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_w[1] !== 1'b0) hi = 1'b1;
        end
        checks++; if (hi !== 1'b0) begin errors++; $display("FAIL rmid_no_done got pulse exp none"); end
        d = 8'($urandom); s = 8'($urandom);
        slave_tx[1] = s;
        base = rec_cnt[1];
        accept(1, d, 1'b1);
        wait_done(1, 200, cyc, hi);
        checks++; if (cyc !== 34 || dout_w[1] !== s) begin errors++; $display("FAIL rmid_next cyc=%0d dout=%h exp 34/%h", cyc, dout_w[1], s); end
        checks++; if (rec_byte[1][base % 64] !== d || rec_cmd[1][base % 64] !== 1'b1) begin errors++; $display("FAIL rmid_slave got %h cmd=%b exp %h cmd=1", rec_byte[1][base % 64], rec_cmd[1][base % 64], d); end
        wait_idle(1, 20, cyc);
        $display("reset_mid inst=1 next din=%h slave=%h dout=%h", d, s, dout_w[1]);
    endtask

    task automatic test_tick_gating();
        logic [7:0] d, s;
        int cyc, ticks, edges, last_edge, bad_iv, bad_en, base;
        logic prev;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom); s = 8'($urandom);
            slave_tx[2] = s;
            base = rec_cnt[2];
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            accept(2, d, 1'b1);
            cyc = 0; ticks = 0; edges = 0; last_edge = -1; bad_iv = 0; bad_en = 0;
            prev = sck_w[2];
            while (done_w[2] !== 1'b1 && cyc < 400) begin
                @(posedge clk); #1;
                cyc++;
                if (en_s[2] === 1'b1) ticks++;
                if (sck_w[2] !== prev) begin
                    edges++;
                    if (en_s[2] !== 1'b1) bad_en++;
                    if (last_edge >= 0 && (cyc - last_edge) != 12) bad_iv++;
                    last_edge = cyc;
                end
                prev = sck_w[2];
            end
            checks++; if (ticks !== 51) begin errors++; $display("FAIL gate_ticks got %0d exp 51", ticks); end
            checks++; if (edges !== 16) begin errors++; $display("FAIL gate_edges got %0d exp 16", edges); end
            checks++; if (bad_iv !== 0) begin errors++; $display("FAIL gate_halfperiod bad=%0d exp 0", bad_iv); end
            checks++; if (bad_en !== 0) begin errors++; $display("FAIL gate_edge_on_tick bad=%0d exp 0", bad_en); end
            checks++; if (dout_w[2] !== s || rec_byte[2][base % 64] !== d) begin errors++; $display("FAIL gate_data dout=%h slave=%h exp %h/%h", dout_w[2], rec_byte[2][base % 64], s, d); end
            wait_idle(2, 100, cyc);
            $display("tick_gating inst=2 din=%h slave=%h dout=%h", d, s, dout_w[2]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_s = '0; last_s = '0; deselect_s = '0;
        for (int k = 0; k < 3; k++) begin
            din_s[k] = 8'h00;
            slave_tx[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_held_cs();
        test_deselect();
        test_start_while_busy();
        test_reset_mid();
        test_tick_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
